// File: rtl/bt_cmd_decoder_pkg.sv
// Shared definitions for the Bluetooth song-step command decoder.
//   - command byte constants ('P','p','N','n','1','7')
//   - parser and UART receiver state encodings
//   - bit-period (DIV) computation and byte classification helpers
package bt_cmd_decoder_pkg;

  localparam logic [7:0] CH_P_UP = 8'h50;
  localparam logic [7:0] CH_P_LO = 8'h70;
  localparam logic [7:0] CH_N_UP = 8'h4E;
  localparam logic [7:0] CH_N_LO = 8'h6E;
  localparam logic [7:0] CH_1    = 8'h31;
  localparam logic [7:0] CH_7    = 8'h37;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GOT_P = 2'd1,
    ST_GOT_N = 2'd2
  } parse_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic logic is_p(input logic [7:0] b);
    return (b == CH_P_UP) || (b == CH_P_LO);
  endfunction

  function automatic logic is_n(input logic [7:0] b);
    return (b == CH_N_UP) || (b == CH_N_LO);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_1) && (b <= CH_7);
  endfunction

endpackage

// File: rtl/bt_uart_rx.sv
// 8N1 UART receiver for the Bluetooth module serial line.
// Ports:
//   CLK   system clock, rising edge
//   RST   synchronous active-low reset
//   RXD   asynchronous serial input, idle high
//   DATA  last received byte (LSB first on the line)
//   VALID one-cycle strobe when a byte with a good stop bit is received
//   FERR  one-cycle strobe when the stop bit sampled low (byte discarded)
//
// state    | meaning
// RX_IDLE  | waiting for a synchronized 1->0 edge
// RX_START | counting to mid start bit; a high sample aborts silently
// RX_DATA  | sampling 8 data bits at each mid-bit
// RX_STOP  | sampling the stop bit at its mid-bit
module bt_uart_rx
  import bt_cmd_decoder_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FERR
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);

  logic             rxd_s1, rxd_s2, rxd_d;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             valid_q, valid_d, ferr_q, ferr_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rxd_s1  <= 1'b1;
      rxd_s2  <= 1'b1;
      rxd_d   <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rxd_s1  <= RXD;
      rxd_s2  <= rxd_s1;
      rxd_d   <= rxd_s2;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rxd_d && !rxd_s2) begin
          state_d = RX_START;
          cnt_d   = CNT_HALF;
        end
      end
      RX_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rxd_s2) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_DATA;
          cnt_d   = CNT_FULL;
          bit_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          sh_d  = {rxd_s2, sh_q[7:1]};
          cnt_d = CNT_FULL;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Back to idle right away so a back-to-back start edge is caught.
          state_d = RX_IDLE;
          valid_d = rxd_s2;
          ferr_d  = !rxd_s2;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign DATA  = sh_q;
  assign VALID = valid_q;
  assign FERR  = ferr_q;

endmodule

// File: rtl/bt_cmd_decoder.sv
// Bluetooth song-step command decoder: receives "P<d>"/"N<d>" (either case,
// d = '1'..'7') over UART and pulses PREV/NEXT with the step count.
// Optional macro BTCMD_TIMEOUT_EN: abandon a half-received command after
// TIMEOUT_MS of silence (pulses CMD_ERR).
// Ports:
//   CLK      system clock, rising edge
//   RST      synchronous active-low reset
//   RXD      asynchronous serial line from the Bluetooth module, idle high
//   PREV     previous-song step count, nonzero for one cycle per command
//   NEXT     next-song step count, nonzero for one cycle per command
//   CMD_ERR  one-cycle pulse on a rejected command, framing error or timeout
//
// state    | meaning
// ST_IDLE  | waiting for a 'P'/'p' or 'N'/'n' byte
// ST_GOT_P | previous-song command letter seen, waiting for the digit
// ST_GOT_N | next-song command letter seen, waiting for the digit
module bt_cmd_decoder
  import bt_cmd_decoder_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int TIMEOUT_MS = 100
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [2:0] PREV,
  output logic [2:0] NEXT,
  output logic       CMD_ERR
);

  logic [7:0]   rx_data;
  logic         rx_valid, rx_ferr;
  parse_state_t state_q, state_d;
  logic [2:0]   prev_q, prev_d, next_q, next_d;
  logic         err_q, err_d;

  bt_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .CLK   (CLK),
    .RST   (RST),
    .RXD   (RXD),
    .DATA  (rx_data),
    .VALID (rx_valid),
    .FERR  (rx_ferr)
  );

`ifdef BTCMD_TIMEOUT_EN
  localparam int TMO_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int TMO_W   = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_MS;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
      next_q  <= '0;
      err_q   <= 1'b0;
`ifdef BTCMD_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      next_q  <= next_d;
      err_q   <= err_d;
`ifdef BTCMD_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = '0;
    next_d  = '0;
    err_d   = rx_ferr;
`ifdef BTCMD_TIMEOUT_EN
    tmo_d   = (tmo_q != '0) ? tmo_q - TMO_W'(1) : tmo_q;
`endif
    if (rx_valid) begin
      // A command letter (re)starts a command from any state.
      if (is_p(rx_data)) begin
        state_d = ST_GOT_P;
`ifdef BTCMD_TIMEOUT_EN
        tmo_d   = TMO_LOAD;
`endif
      end else if (is_n(rx_data)) begin
        state_d = ST_GOT_N;
`ifdef BTCMD_TIMEOUT_EN
        tmo_d   = TMO_LOAD;
`endif
      end else if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        if (is_digit(rx_data)) begin
          // '1'..'7' are 0x31..0x37, so the low 3 bits are the step count.
          if (state_q == ST_GOT_P) prev_d = rx_data[2:0];
          else                     next_d = rx_data[2:0];
        end else begin
          err_d = 1'b1;
        end
      end
    end
`ifdef BTCMD_TIMEOUT_EN
    else if (state_q != ST_IDLE && tmo_q == '0) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
`endif
  end

  assign PREV    = prev_q;
  assign NEXT    = next_q;
  assign CMD_ERR = err_q;

endmodule

// File: tb/tb_bt_cmd_decoder.sv
module tb_bt_cmd_decoder;

  localparam int CLK_FREQ = 153_600;
  localparam int BAUD     = 9600;
  localparam int DIV      = 16;     // 153600 / 9600
  localparam int TMO_CYC  = 153;    // 153600 / 1000 * 1 ms

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RXD = 1'b1;
  logic [2:0] PREV, NEXT;
  logic       CMD_ERR;

  bt_cmd_decoder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_MS(1)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .RXD     (RXD),
    .PREV    (PREV),
    .NEXT    (NEXT),
    .CMD_ERR (CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor sampled mid-cycle.
  int         n_prev, n_next, n_err, n_both, next_cyc;
  logic [2:0] last_prev, last_next;
  always @(negedge CLK) begin
    if (PREV != 3'd0) begin n_prev++; last_prev = PREV; end
    if (NEXT != 3'd0) begin n_next++; last_next = NEXT; next_cyc = cyc; end
    if (CMD_ERR) n_err++;
    if (PREV != 3'd0 && NEXT != 3'd0) n_both++;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int t_start;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_prev = 0; n_next = 0; n_err = 0;
    last_prev = 3'd0; last_next = 3'd0; next_cyc = -1;
  endtask

  task automatic idle(input int n);
    RXD = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RXD = 1'b0;
    t_start = cyc;
    repeat (DIV) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (DIV) @(negedge CLK);
    end
    RXD = stop;
    repeat (DIV) @(negedge CLK);
    RXD = 1'b1;
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    idle(2 * DIV);
  endtask

  initial begin
    n_both = 0;
    clr();
    @(negedge CLK);
    repeat (4) @(negedge CLK);
    check("rst_prev", PREV, 0);
    check("rst_next", NEXT, 0);
    check("rst_err", CMD_ERR, 0);
    RST = 1'b1;
    idle(4);

    // 'N','3': start of second byte at cyc c -> pulse seen at c + 12 + 9*DIV
    clr();
    send_byte(8'h4E, 1'b1);
    send_byte(8'h33, 1'b1);
    idle(2 * DIV);
    check("n3_next_cnt", n_next, 1);
    check("n3_next_val", last_next, 3);
    check("n3_prev_cnt", n_prev, 0);
    check("n3_err_cnt", n_err, 0);
    check("n3_latency", next_cyc - t_start, 12 + 9 * DIV);

    clr(); send2(8'h70, 8'h37);
    check("p7_prev_cnt", n_prev, 1);
    check("p7_prev_val", last_prev, 7);
    check("p7_next_cnt", n_next, 0);

    clr();
    send_byte(8'h50, 1'b1);
    send2(8'h4E, 8'h32);
    check("pn2_next_cnt", n_next, 1);
    check("pn2_next_val", last_next, 2);
    check("pn2_prev_cnt", n_prev, 0);
    check("pn2_err_cnt", n_err, 0);

    clr(); send2(8'h6E, 8'h31);
    check("n1_next_val", last_next, 1);
    check("n1_err_cnt", n_err, 0);

    clr(); send2(8'h50, 8'h39);
    check("p9_err_cnt", n_err, 1);
    check("p9_outs", n_prev + n_next, 0);

    clr(); send2(8'h70, 8'h30);
    check("p0_err_cnt", n_err, 1);
    clr(); send2(8'h4E, 8'h38);
    check("n8_err_cnt", n_err, 1);
    check("n8_outs", n_prev + n_next, 0);

    // framing error on 'N': error pulse, parser must not leave IDLE
    clr();
    send_byte(8'h4E, 1'b0);
    idle(2 * DIV);
    check("ferr_err_cnt", n_err, 1);
    send2(8'h7A, 8'h33);
    check("ferr_idle_next", n_next, 0);
    check("ferr_idle_err", n_err, 1);

    // 2-cycle glitch is rejected at the start-bit mid sample
    clr();
    RXD = 1'b0;
    repeat (2) @(negedge CLK);
    idle(3 * DIV);
    check("glitch_outs", n_prev + n_next + n_err, 0);
    send2(8'h4E, 8'h35);
    check("glitch_recover", last_next, 5);

    // reset in the middle of the '1' after 'N'
    clr();
    send_byte(8'h4E, 1'b1);
    RXD = 1'b0;
    repeat (4 * DIV) @(negedge CLK);
    RXD = 1'b1;
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    idle(8 * DIV);
    check("rstmid_outs", n_prev + n_next + n_err, 0);
    send_byte(8'h31, 1'b1);
    idle(2 * DIV);
    check("rstmid_cmd_gone", n_prev + n_next + n_err, 0);

    // inter-byte gap of 2 ms
    clr();
    send_byte(8'h4E, 1'b1);
    idle(2 * TMO_CYC + 10);
    send_byte(8'h34, 1'b1);
    idle(2 * DIV);
`ifdef BTCMD_TIMEOUT_EN
    check("tmo_err_cnt", n_err, 1);
    check("tmo_next_cnt", n_next, 0);
`else
    check("tmo_err_cnt", n_err, 0);
    check("tmo_next_val", last_next, 4);
`endif

    check("never_both", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
